// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg: flag-class encodings and flag bit positions shared by
// the flag producer (flag_unit) and the flag tester on the PC-mux side.
package flag_unit_pkg;

    // OP_FL flag-class encodings; unlisted codes behave as FL_NONE.
    typedef enum logic [2:0] {
        FL_ADD   = 3'b000,
        FL_SUB   = 3'b001,
        FL_LOGIC = 3'b010,
        FL_SHIFT = 3'b011,
        FL_LOAD  = 3'b100,
        FL_NONE  = 3'b111
    } fl_op_e;

    // Bit positions inside the packed {O,S,C,Z} flag vector.
    localparam int FLAG_O = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/flag_calc.sv
// flag_calc: combinational next-flag generator. Inputs: operands A/B,
// result R, adder carry, shifter bit-out, flag class. Outputs: next
// {O,S,C,Z} and whether the class writes the flags at all.
module flag_calc
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_c_alu,
    input  logic             i_shift_out,
    input  logic [2:0]       i_op_fl,
    output flags_t           o_flags,
    output logic             o_upd
);

    localparam int MSB = WIDTH - 1;

    logic w_a_msb;
    logic w_b_msb;
    logic w_r_msb;
    logic w_zero;
    logic w_unused;

    assign w_a_msb = i_a[MSB];
    assign w_b_msb = i_b[MSB];
    assign w_r_msb = i_r[MSB];
    assign w_zero  = (i_r == '0);

    // Only the sign bits of the operands matter for overflow.
    assign w_unused = ^{i_a[MSB-1:0], i_b[MSB-1:0]};

    always_comb begin
        o_flags = '0;
        o_upd   = 1'b1;
        o_flags[FLAG_S] = w_r_msb;
        o_flags[FLAG_Z] = w_zero;
        case (i_op_fl)
            FL_ADD: begin
                o_flags[FLAG_C] = i_c_alu;
                o_flags[FLAG_O] = (w_a_msb == w_b_msb)
                                && (w_r_msb != w_a_msb);
            end
            FL_SUB: begin
                // Carry is active-high "no borrow" straight from the adder.
                o_flags[FLAG_C] = i_c_alu;
                o_flags[FLAG_O] = (w_a_msb != w_b_msb)
                                && (w_r_msb != w_a_msb);
            end
            FL_LOGIC: begin
                o_flags[FLAG_C] = 1'b0;
            end
            FL_SHIFT: begin
                o_flags[FLAG_C] = i_shift_out;
            end
            FL_LOAD: begin
                o_flags = i_r[3:0];
            end
            default: begin
                o_flags = '0;
                o_upd   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: architectural O/S/C/Z flag registers, one-deep shadow for
// save/restore, and sticky overflow. Inputs: ALU operands/result/carry,
// shifter bit-out, flag class, valid, stall, save, restore, clear-SO.
// Outputs: registered O, S, C, Z and SO, all straight from flops.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_c_alu,
    input  logic             i_shift_out,
    input  logic [2:0]       i_op_fl,
    input  logic             i_valid,
    input  logic             i_stall,
    input  logic             i_save,
    input  logic             i_restore,
    input  logic             i_clr_so,
    output logic             o_o,
    output logic             o_s,
    output logic             o_c,
    output logic             o_z,
    output logic             o_so
);

    flags_t r_flags;
    flags_t r_shadow;
    logic   r_so;

    flags_t w_next;
    logic   w_calc_upd;
    logic   w_upd;
    logic   w_set_so;

    flag_calc #(
        .WIDTH       (WIDTH)
    ) u_calc (
        .i_a         (i_a),
        .i_b         (i_b),
        .i_r         (i_r),
        .i_c_alu     (i_c_alu),
        .i_shift_out (i_shift_out),
        .i_op_fl     (i_op_fl),
        .o_flags     (w_next),
        .o_upd       (w_calc_upd)
    );

    assign w_upd = i_valid && w_calc_upd;

    // SO tracks the O value actually written, so restore wins over update.
    assign w_set_so = i_restore ? r_shadow[FLAG_O]
                                : (w_upd && w_next[FLAG_O]);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_flags  <= '0;
            r_shadow <= '0;
            r_so     <= 1'b0;
        end else if (!i_stall) begin
            if (i_restore) begin
                r_flags <= r_shadow;
            end else if (w_upd) begin
                r_flags <= w_next;
            end
            // Captures the pre-update flags; with restore this is a swap.
            if (i_save) begin
                r_shadow <= r_flags;
            end
            if (w_set_so) begin
                r_so <= 1'b1;
            end else if (i_clr_so) begin
                r_so <= 1'b0;
            end
        end
    end

    assign o_o  = r_flags[FLAG_O];
    assign o_s  = r_flags[FLAG_S];
    assign o_c  = r_flags[FLAG_C];
    assign o_z  = r_flags[FLAG_Z];
    assign o_so = r_so;

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed vectors for flag_unit with a queue scoreboard;
// a negedge monitor pops each expected {O,S,C,Z,SO} and compares.
module tb_flag_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        c_alu;
    logic        sh;
    logic [2:0]  op;
    logic        valid;
    logic        stall;
    logic        save;
    logic        restore;
    logic        clr_so;
    logic        o_o;
    logic        o_s;
    logic        o_c;
    logic        o_z;
    logic        o_so;

    typedef struct {
        string      nm;
        logic [4:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_total;
    int   n_pass;

    flag_unit #(
        .WIDTH       (16)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_a         (a),
        .i_b         (b),
        .i_r         (r),
        .i_c_alu     (c_alu),
        .i_shift_out (sh),
        .i_op_fl     (op),
        .i_valid     (valid),
        .i_stall     (stall),
        .i_save      (save),
        .i_restore   (restore),
        .i_clr_so    (clr_so),
        .o_o         (o_o),
        .o_s         (o_s),
        .o_c         (o_c),
        .o_z         (o_z),
        .o_so        (o_so)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: outputs are flop-driven, so negedge is a stable sample point.
    initial begin
        exp_t       e;
        logic [4:0] act;
        n_total = 0;
        n_pass  = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o_o, o_s, o_c, o_z, o_so};
                n_total++;
                if (act === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got OSCZ_SO=%b required %b",
                             e.nm, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(
        input logic [2:0]  t_op,
        input logic [15:0] t_a,
        input logic [15:0] t_b,
        input logic [15:0] t_r,
        input logic        t_c,
        input logic        t_sh,
        input logic        t_v,
        input logic        t_st,
        input logic        t_sv,
        input logic        t_rs,
        input logic        t_cl,
        input string       t_nm,
        input logic [4:0]  t_exp
    );
        op      = t_op;
        a       = t_a;
        b       = t_b;
        r       = t_r;
        c_alu   = t_c;
        sh      = t_sh;
        valid   = t_v;
        stall   = t_st;
        save    = t_sv;
        restore = t_rs;
        clr_so  = t_cl;
        @(posedge clk);
        #1;
        sb.push_back('{t_nm, t_exp});
        @(negedge clk);
    endtask

    task automatic idle(input string t_nm, input logic [4:0] t_exp);
        step(3'b111, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t_nm, t_exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        a       = '0;
        b       = '0;
        r       = '0;
        c_alu   = 1'b0;
        sh      = 1'b0;
        op      = 3'b111;
        valid   = 1'b0;
        stall   = 1'b0;
        save    = 1'b0;
        restore = 1'b0;
        clr_so  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        sb.push_back('{"reset", 5'b00000});
        @(negedge clk);
        rst_n = 1'b1;

        // Expected order: {O,S,C,Z,SO}
        step(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0,
             1, 0, 0, 0, 0, "add_ovf", 5'b11001);
        step(3'b001, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0,
             1, 0, 0, 0, 0, "sub_zero", 5'b00111);
        step(3'b111, 16'h0, 16'h0, 16'h0005, 1'b0, 1'b0,
             1, 0, 0, 0, 0, "op_none", 5'b00111);
        step(3'b101, 16'h0, 16'h0, 16'h0008, 1'b0, 1'b0,
             1, 0, 0, 0, 0, "op_rsvd", 5'b00111);
        step(3'b010, 16'h0, 16'h0, 16'h8000, 1'b1, 1'b0,
             1, 0, 0, 0, 0, "logic", 5'b01001);
        step(3'b011, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b1,
             1, 0, 0, 0, 0, "shift", 5'b00111);
        step(3'b111, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0,
             0, 0, 0, 0, 1, "clr_so", 5'b00110);
        step(3'b100, 16'h0, 16'h0, 16'h0005, 1'b0, 1'b0,
             1, 0, 0, 0, 0, "load_5", 5'b01010);
        step(3'b000, 16'h8000, 16'h8001, 16'h0001, 1'b0, 1'b0,
             1, 0, 1, 0, 0, "save_add", 5'b10001);
        step(3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0,
             1, 0, 0, 1, 0, "restore", 5'b01011);
        step(3'b100, 16'h0, 16'h0, 16'h000E, 1'b0, 1'b0,
             1, 0, 0, 0, 0, "load_E", 5'b11101);
        step(3'b111, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0,
             0, 0, 1, 1, 0, "swap", 5'b01011);
        step(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0,
             1, 1, 1, 0, 1, "stall", 5'b01011);
        step(3'b111, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0,
             0, 0, 0, 1, 0, "restore2", 5'b11101);
        step(3'b111, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0,
             0, 0, 0, 0, 1, "clr_so2", 5'b11100);
        step(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0,
             1, 0, 0, 0, 1, "so_set_wins", 5'b11001);
        step(3'b100, 16'h0, 16'h0, 16'h000F, 1'b0, 1'b0,
             1, 0, 0, 0, 0, "load_F", 5'b11111);

        // Asynchronous reset mid-cycle with a qualifying load still applied.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.push_back('{"async_rst", 5'b00000});
        @(posedge clk);
        #1;
        sb.push_back('{"rst_hold", 5'b00000});
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_release", 5'b00000);
        step(3'b100, 16'h0, 16'h0, 16'h0003, 1'b0, 1'b0,
             1, 0, 0, 0, 0, "load_3", 5'b00110);

        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
